// File: rtl/cpu_params_pkg.sv
// Shared CPU constants: access-size encodings and helpers for lane masks.
package cpu_params_pkg;

  localparam logic [2:0] SZ_BYTE = 3'd1;
  localparam logic [2:0] SZ_HALF = 3'd2;
  localparam logic [2:0] SZ_WORD = 3'd4;

  // An all-zero mask doubles as the "illegal size" indication.
  function automatic logic [3:0] size_mask(input logic [2:0] size);
    case (size)
      SZ_BYTE: size_mask = 4'b0001;
      SZ_HALF: size_mask = 4'b0011;
      SZ_WORD: size_mask = 4'b1111;
      default: size_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/cpu_structs_pkg.sv
// Shared CPU types: load/store responder FSM state encoding.
package cpu_structs_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_WAIT2,
    ST_ACCESS2,
    ST_RESP
  } ls_state_e;

endpackage

// File: rtl/ls_load_align.sv
// Combinational load lane extraction and sign/zero extension over a two-word
// little-endian window (lo word holds the addressed byte, hi word follows it).
module ls_load_align
  import cpu_params_pkg::*;
(
  input  logic [31:0] lo_word_i,
  input  logic [31:0] hi_word_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  size_i,
  input  logic        zero_ext_i,
  output logic [31:0] data_o
);

  logic [31:0] lanes;

  always_comb begin
    lanes = 32'({hi_word_i, lo_word_i} >> {offset_i, 3'b000});
    case (size_i)
      SZ_BYTE: data_o = zero_ext_i ? {24'h0, lanes[7:0]} : {{24{lanes[7]}}, lanes[7:0]};
      SZ_HALF: data_o = zero_ext_i ? {16'h0, lanes[15:0]} : {{16{lanes[15]}}, lanes[15:0]};
      default: data_o = lanes;
    endcase
  end

endmodule

// File: rtl/ls_mem_responder.sv
// Load/store memory responder with byte-writable word memory and wait states.
// Define LS_MISALIGN_SPLIT_EN to service misaligned accesses as two word accesses.
module ls_mem_responder
  import cpu_params_pkg::*;
  import cpu_structs_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rd,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic        req_zero_ext,
  input  logic [31:0] req_wr_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err
);

  localparam int          AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  WS_LAST = 4'(WAIT_STATES - 1);
  localparam logic [30:0] DEPTH_W = 31'(DEPTH_WORDS);

  ls_state_e    state_q;
  logic [3:0]   wait_cnt_q;
  logic [AW+1:0] addr_q;
  logic [31:0]  wdata_q;
  logic [2:0]   size_q;
  logic         rd_q, zext_q, err_q;
  logic         req_ready_q, rsp_valid_q, rsp_err_q;
  logic [31:0]  rsp_data_q, rd_word_q, load_data, align_lo;
  logic [31:0]  mem [DEPTH_WORDS];

  logic         in_size_ok, in_mis, in_oor_a, in_err;
  logic         wr_en;
  logic [3:0]   wr_be;
  logic [31:0]  wr_data;
  logic [AW-1:0] wr_word, rd_word_idx;

`ifdef LS_MISALIGN_SPLIT_EN
  logic         split_q, in_split, in_oor_b;
  logic [7:0]   in_be8, wr_be8;
  logic [63:0]  wr_data64;
  logic [31:0]  word_a_q;
`endif

  // Request classification happens once, on the inputs, at accept time.
  always_comb begin
    in_size_ok = size_mask(req_size) != 4'b0000;
    in_mis     = (req_size == SZ_HALF && req_addr[0]) ||
                 (req_size == SZ_WORD && req_addr[1:0] != 2'b00);
    in_oor_a   = {1'b0, req_addr[31:2]} >= DEPTH_W;
`ifdef LS_MISALIGN_SPLIT_EN
    in_be8     = {4'b0000, size_mask(req_size)} << req_addr[1:0];
    in_oor_b   = ({1'b0, req_addr[31:2]} + 31'd1) >= DEPTH_W;
    in_split   = in_size_ok && in_mis;
    in_err     = !in_size_ok || in_oor_a || ((|in_be8[7:4]) && in_oor_b);
`else
    in_err     = !in_size_ok || in_mis || in_oor_a;
`endif
  end

  always_comb begin
    rd_word_idx = (state_q == ST_IDLE) ? req_addr[AW+1:2] : addr_q[AW+1:2];
    wr_word     = addr_q[AW+1:2];
    wr_en       = (state_q == ST_ACCESS) && !rd_q && !err_q;
    align_lo    = rd_word_q;
`ifdef LS_MISALIGN_SPLIT_EN
    wr_be8    = {4'b0000, size_mask(size_q)} << addr_q[1:0];
    wr_data64 = {32'h0, wdata_q} << {addr_q[1:0], 3'b000};
    wr_be     = wr_be8[3:0];
    wr_data   = wr_data64[31:0];
    if ((state_q == ST_ACCESS && split_q) || state_q == ST_WAIT2 || state_q == ST_ACCESS2)
      rd_word_idx = addr_q[AW+1:2] + 1'b1;
    if (state_q == ST_ACCESS2) begin
      wr_word  = addr_q[AW+1:2] + 1'b1;
      wr_be    = wr_be8[7:4];
      wr_data  = wr_data64[63:32];
      wr_en    = !rd_q && !err_q;
      align_lo = word_a_q;
    end
`else
    wr_be   = size_mask(size_q) << addr_q[1:0];
    wr_data = wdata_q << {addr_q[1:0], 3'b000};
`endif
  end

  // Read port is registered; its address tracks the word the next ACCESS needs.
  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[wr_word][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
    rd_word_q <= mem[rd_word_idx];
  end

  ls_load_align u_align (
    .lo_word_i  (align_lo),
    .hi_word_i  (rd_word_q),
    .offset_i   (addr_q[1:0]),
    .size_i     (size_q),
    .zero_ext_i (zext_q),
    .data_o     (load_data)
  );

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= 4'd0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            addr_q      <= req_addr[AW+1:0];
            wdata_q     <= req_wr_data;
            size_q      <= req_size;
            rd_q        <= req_rd;
            zext_q      <= req_zero_ext;
            err_q       <= in_err;
`ifdef LS_MISALIGN_SPLIT_EN
            split_q     <= in_split;
`endif
            wait_cnt_q  <= WS_LAST;
            state_q     <= (WAIT_STATES == 0) ? ST_ACCESS : ST_WAIT;
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (wait_cnt_q == 4'd0) state_q <= ST_ACCESS;
          else                    wait_cnt_q <= wait_cnt_q - 4'd1;
        end
        ST_ACCESS: begin
`ifdef LS_MISALIGN_SPLIT_EN
          word_a_q <= rd_word_q;
          if (split_q) begin
            wait_cnt_q <= WS_LAST;
            state_q    <= (WAIT_STATES == 0) ? ST_ACCESS2 : ST_WAIT2;
          end else begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= err_q;
            rsp_data_q  <= (rd_q && !err_q) ? load_data : 32'h0;
            state_q     <= ST_RESP;
          end
        end
        ST_WAIT2: begin
          if (wait_cnt_q == 4'd0) state_q <= ST_ACCESS2;
          else                    wait_cnt_q <= wait_cnt_q - 4'd1;
        end
        ST_ACCESS2: begin
`endif
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= err_q;
          rsp_data_q  <= (rd_q && !err_q) ? load_data : 32'h0;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'h0;
            rsp_err_q   <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_ls_mem_responder.sv
// Self-checking bench for ls_mem_responder: directed cases, mid-transaction
// reset, and randomized traffic against a byte-array reference model.
module tb_ls_mem_responder;

  localparam int DEPTH = 64;
  localparam int WS    = 2;
`ifdef LS_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_rd = 1'b0;
  logic [31:0] req_addr = '0;
  logic [2:0]  req_size = '0;
  logic        req_zero_ext = 1'b0;
  logic [31:0] req_wr_data = '0;
  logic        rsp_ready = 1'b0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_data;

  logic [7:0]  mem_m [4*DEPTH];
  int          n_vec = 0;
  int          n_fail = 0;

  ls_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
    .clk_in       (clk),
    .reset_in     (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_rd       (req_rd),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_zero_ext (req_zero_ext),
    .req_wr_data  (req_wr_data),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Reference: byte-addressed memory, errors and latency from the access rules.
  task automatic model(input bit rd, input logic [31:0] addr, input logic [2:0] size,
                       input bit zext, input logic [31:0] wd,
                       output logic [31:0] data, output bit err, output int lat);
    int n;
    bit mis;
    longint ba;
    n   = int'(size);
    err = !(n == 1 || n == 2 || n == 4);
    mis = !err && ((longint'(addr) % n) != 0);
    if (mis && !SPLIT) err = 1'b1;
    if (!err) begin
      for (int i = 0; i < n; i++) begin
        ba = longint'(addr) + i;
        if (ba / 4 >= DEPTH) err = 1'b1;
      end
    end
    lat  = (mis && SPLIT) ? 2*WS + 3 : WS + 2;
    data = 32'h0;
    if (!err) begin
      for (int i = 0; i < n; i++) begin
        ba = longint'(addr) + i;
        if (rd) data = data | (32'(mem_m[int'(ba)]) << (8*i));
        else    mem_m[int'(ba)] = wd[8*i +: 8];
      end
      if (rd && !zext && n < 4 && data[8*n-1]) data = data | (32'hFFFF_FFFF << (8*n));
    end
  endtask

  task automatic txn(input bit rd, input logic [31:0] addr, input logic [2:0] size,
                     input bit zext, input logic [31:0] wd, input int hold,
                     input bit lit, input logic [31:0] lit_data, input bit lit_err);
    logic [31:0] ed;
    bit ee;
    int el;
    int n;
    model(rd, addr, size, zext, wd, ed, ee, el);
    @(negedge clk);
    req_rd = rd; req_addr = addr; req_size = size; req_zero_ext = zext; req_wr_data = wd;
    req_valid = 1'b1;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("accept_ready", 32'(req_ready), 32'd1);
    if (req_ready !== 1'b1) begin req_valid = 1'b0; return; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (rsp_valid !== 1'b1 && n < 40);
    chk("latency", 32'(n), 32'(el));
    chk("rsp_data", rsp_data, ed);
    chk("rsp_err", 32'(rsp_err), 32'(ee));
    chk("req_ready_in_resp", 32'(req_ready), 32'd0);
    if (lit) begin
      chk("directed_data", rsp_data, lit_data);
      chk("directed_err", 32'(rsp_err), 32'(lit_err));
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_data", rsp_data, ed);
      chk("hold_err", 32'(rsp_err), 32'(ee));
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("post_valid", 32'(rsp_valid), 32'd0);
    chk("post_req_ready", 32'(req_ready), 32'd1);
    $display("txn rd=%0d addr=%h size=%0d zext=%0d wd=%h -> data=%h err=%0d lat=%0d",
             rd, addr, size, zext, wd, ed, ee, el);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] sz_tbl [8];
    logic [31:0] a, w;
    int n;
    sz_tbl = '{3'd1, 3'd2, 3'd4, 3'd1, 3'd2, 3'd4, 3'd3, 3'd0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("release_req_ready", 32'(req_ready), 32'd1);

    // Fill memory so every model byte is known
    for (int i = 0; i < DEPTH; i++) txn(1'b0, 32'(4*i), 3'd4, 1'b0, $urandom, 0, 1'b0, 32'h0, 1'b0);

    // Byte/half lanes and extension
    txn(1'b0, 32'h10, 3'd4, 1'b0, 32'hDEADBEEF, 0, 1'b1, 32'h0, 1'b0);
    txn(1'b1, 32'h13, 3'd1, 1'b0, 32'h0, 0, 1'b1, 32'hFFFFFFDE, 1'b0);
    txn(1'b1, 32'h13, 3'd1, 1'b1, 32'h0, 1, 1'b1, 32'h000000DE, 1'b0);
    txn(1'b0, 32'h12, 3'd2, 1'b0, 32'hAAAA1234, 0, 1'b1, 32'h0, 1'b0);
    txn(1'b1, 32'h10, 3'd4, 1'b0, 32'h0, 0, 1'b1, 32'h1234BEEF, 1'b0);
    txn(1'b1, 32'h12, 3'd2, 1'b0, 32'h0, 0, 1'b1, 32'h00001234, 1'b0);
    txn(1'b1, 32'h10, 3'd2, 1'b1, 32'h0, 0, 1'b1, 32'h0000BEEF, 1'b0);

    // Misaligned word load
    txn(1'b0, 32'h14, 3'd4, 1'b0, 32'h55667788, 0, 1'b1, 32'h0, 1'b0);
    txn(1'b1, 32'h11, 3'd4, 1'b0, 32'h0, 2, 1'b1, SPLIT ? 32'h881234BE : 32'h0, !SPLIT);
    txn(1'b1, 32'h10, 3'd4, 1'b0, 32'h0, 0, 1'b1, 32'h1234BEEF, 1'b0);

    // Response held for three cycles with rsp_ready low
    txn(1'b1, 32'h14, 3'd4, 1'b0, 32'h0, 3, 1'b1, 32'h55667788, 1'b0);

    // Out-of-range and illegal size
    txn(1'b1, 32'(4*DEPTH), 3'd4, 1'b0, 32'h0, 0, 1'b1, 32'h0, 1'b1);
    txn(1'b0, 32'h10, 3'd3, 1'b0, 32'h0000005A, 0, 1'b1, 32'h0, 1'b1);
    txn(1'b1, 32'h10, 3'd4, 1'b0, 32'h0, 0, 1'b1, 32'h1234BEEF, 1'b0);

    // Reset while a store waits: no response, no write
    @(negedge clk);
    req_rd = 1'b0; req_addr = 32'h20; req_size = 3'd4; req_wr_data = 32'hCAFEF00D;
    req_valid = 1'b1;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("rst_case_accept", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_rsp_data", rsp_data, 32'h0);
    chk("midrst_rsp_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_release_ready", 32'(req_ready), 32'd1);
    chk("midrst_release_valid", 32'(rsp_valid), 32'd0);
    txn(1'b1, 32'h20, 3'd4, 1'b0, 32'h0, 0, 1'b0, 32'h0, 1'b0);

    // Randomized traffic
    for (int t = 0; t < 160; t++) begin
      a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 4*DEPTH + 3));
      w = $urandom;
      txn(1'($urandom_range(0, 1)), a, sz_tbl[$urandom_range(0, 7)], 1'($urandom_range(0, 1)),
          w, $urandom_range(0, 3), 1'b0, 32'h0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
